wash_cycle: RTL and testbench

- Downstream stage of the order-entry block; takes over after that block raises its start-permitted flag.
- On a start request it:
  - checks the BCD balance against the price of the selected mode and load;
  - deducts the charge;
  - sequences wash -> rinse -> spin with per-second BCD countdowns;
  - reports completion.
- Provides remaining time and phase for the seven-segment scanners and state lights.

---
 rtl/wash_cycle.sv | 170 +++++++++++++++++
 tb/tb_wash_cycle.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wash_cycle.sv
// wash_cycle: charges a BCD balance for the chosen programme and runs wash/rinse/spin BCD countdowns
module wash_cycle #(
   parameter int          TICK      = 100000000,
   parameter int          END_S     = 3,
   parameter logic [11:0] SURCHARGE = 12'h002,
   parameter int          HEAVY_ADD = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  mode,
   input  logic [11:0] bal_in,
   input  logic [7:0]  wt,
   input  logic        pause,
   input  logic        abort,
   output logic [11:0] bal_out,
   output logic [7:0]  sec,
   output logic [1:0]  phase,
   output logic [2:0]  st_light,
   output logic        busy,
   output logic        paused,
   output logic        done,
   output logic        err
);
   localparam int TW = TICK > 1 ? $clog2(TICK) : 1;
   localparam logic [7:0] HEAVY_BCD = 8'((HEAVY_ADD / 10) * 16 + HEAVY_ADD % 10);

   typedef enum logic [2:0] {IDLE, WASH, RINSE, SPIN, PAUSE, DONE, ERR} state_t;

   state_t state, n_state, res, n_res, first, after, shown;
   logic [TW-1:0] tick, n_tick;
   logic [7:0] hold, n_hold, n_sec, w_d, r_d, s_d, n_w, n_r, n_s, t_w, in_w, in_r, in_s;
   logic [11:0] n_bal, price, cost;
   logic n_done, heavy, bad, run, wrap;

   function automatic logic [11:0] bcd_add(input logic [11:0] a, input logic [11:0] b);
      logic [4:0] s;
      logic c;
      logic [11:0] r;
      c = 1'b0;
      r = 12'h000;
      for (int i = 0; i < 3; i++) begin
         s = {1'b0, a[4*i+:4]} + {1'b0, b[4*i+:4]} + {4'h0, c};
         c = s > 5'd9;
         r[4*i+:4] = c ? 4'(s - 5'd10) : s[3:0];
      end
      return r;
   endfunction

   function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
      logic [4:0] d;
      logic bw;
      logic [11:0] r;
      bw = 1'b0;
      r = 12'h000;
      for (int i = 0; i < 3; i++) begin
         d = {1'b0, a[4*i+:4]} - {1'b0, b[4*i+:4]} - {4'h0, bw};
         bw = d[4];
         r[4*i+:4] = bw ? 4'(d + 5'd10) : d[3:0];
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] s);
      return s[3:0] == 4'h0 ? {s[7:4] - 4'h1, 4'h9} : s - 8'h01;
   endfunction

   // k is the earliest phase still allowed: 0 wash, 1 rinse, 2 spin, 3 none
   function automatic state_t nxt(input logic [1:0] k, input logic [7:0] w, input logic [7:0] r, input logic [7:0] s);
      return (k == 2'd0 && w != 8'h00) ? WASH : (k <= 2'd1 && r != 8'h00) ? RINSE : (k <= 2'd2 && s != 8'h00) ? SPIN : DONE;
   endfunction

   function automatic logic [7:0] dur(input state_t st, input logic [7:0] w, input logic [7:0] r, input logic [7:0] s);
      return st == WASH ? w : st == RINSE ? r : st == SPIN ? s : 8'h00;
   endfunction

   assign price = mode == 2'd0 ? 12'h005 : mode == 2'd1 ? 12'h008 : mode == 2'd2 ? 12'h012 : 12'h004;
   assign t_w   = mode == 2'd0 ? 8'h20 : mode == 2'd1 ? 8'h15 : mode == 2'd2 ? 8'h30 : 8'h00;
   assign in_r  = mode == 2'd0 || mode == 2'd1 ? 8'h10 : mode == 2'd2 ? 8'h15 : 8'h00;
   assign in_s  = mode == 2'd0 ? 8'h10 : mode == 2'd1 ? 8'h05 : mode == 2'd2 ? 8'h15 : 8'h20;
   assign heavy = wt[7:4] != 4'h0;
   assign cost  = heavy ? bcd_add(price, SURCHARGE) : price;
   assign in_w  = heavy && t_w != 8'h00 ? 8'(bcd_add({4'h0, t_w}, {4'h0, HEAVY_BCD})) : t_w;
   assign bad   = wt[7:4] > 4'd9 || wt[3:0] > 4'd9 || bal_in < cost;
   assign first = nxt(2'd0, in_w, in_r, in_s);
   assign after = nxt(state == WASH ? 2'd1 : state == RINSE ? 2'd2 : 2'd3, w_d, r_d, s_d);
   assign run   = state == WASH || state == RINSE || state == SPIN;
   assign wrap  = tick == TW'(TICK - 1);

   // next state and datapath: start in IDLE, then abort > pause > tick
   always_comb begin
      n_state = state;
      n_res = res;
      n_tick = tick;
      n_hold = hold;
      n_sec = sec;
      n_bal = bal_out;
      n_w = w_d;
      n_r = r_d;
      n_s = s_d;
      n_done = 1'b0;
      if (state == IDLE) begin
         if (start) begin
            n_tick = '0;
            n_hold = 8'h00;
            n_state = bad ? ERR : first;
            n_bal = bad ? bal_in : bcd_sub(bal_in, cost);
            n_sec = bad ? 8'h00 : dur(first, in_w, in_r, in_s);
            n_done = !bad && first == DONE;
            n_w = in_w;
            n_r = in_r;
            n_s = in_s;
         end
      end else if (abort) begin
         n_state = IDLE;
         n_sec = 8'h00;
         n_tick = '0;
      end else if (pause && (run || state == PAUSE)) begin
         n_state = run ? PAUSE : res;
         n_res = run ? state : res;
      end else if (state != PAUSE) begin
         n_tick = wrap ? '0 : tick + TW'(1);
         if (wrap && run && sec == 8'h01) begin
            n_state = after;
            n_sec = dur(after, w_d, r_d, s_d);
            n_done = after == DONE;
            n_hold = 8'h00;
         end else if (wrap && run) begin
            n_sec = bcd_dec(sec);
         end else if (wrap) begin
            n_hold = hold + 8'd1;
            n_state = hold == 8'(END_S - 1) ? IDLE : state;
         end
      end
   end

   // state and datapath registers, cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         res <= IDLE;
         tick <= '0;
         hold <= 8'h00;
         sec <= 8'h00;
         bal_out <= 12'h000;
         w_d <= 8'h00;
         r_d <= 8'h00;
         s_d <= 8'h00;
         done <= 1'b0;
      end else begin
         state <= n_state;
         res <= n_res;
         tick <= n_tick;
         hold <= n_hold;
         sec <= n_sec;
         bal_out <= n_bal;
         w_d <= n_w;
         r_d <= n_r;
         s_d <= n_s;
         done <= n_done;
      end
   end

   assign shown    = state == PAUSE ? res : state;
   assign phase    = shown == WASH ? 2'd1 : shown == RINSE ? 2'd2 : shown == SPIN ? 2'd3 : 2'd0;
   assign st_light = {state == SPIN, state == RINSE, state == WASH};
   assign busy     = run || state == PAUSE;
   assign paused   = state == PAUSE;
   assign err      = state == ERR;
endmodule

// File: tb/tb_wash_cycle.sv
// tb_wash_cycle: scoreboard bench; expectations are queued with their due cycle and checked on the falling edge
module tb_wash_cycle;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, abort = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [11:0] bal_in = 12'h000;
   logic [7:0] wt = 8'h00;
   logic [11:0] bal_out;
   logic [7:0] sec;
   logic [1:0] phase;
   logic [2:0] st_light;
   logic busy, paused, done, err;

   typedef enum int {S_BAL, S_SEC, S_PH, S_LT, S_BUSY, S_PSD, S_DONE, S_ERR} sig_e;
   typedef struct {
      int at;
      sig_e s;
      logic [11:0] v;
      string tag;
   } ent_t;

   ent_t q[$];
   int cyc = 0, vectors = 0, miscompares = 0, done_cnt = 0, c = 0, c2 = 0;

   wash_cycle #(.TICK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .bal_in(bal_in), .wt(wt),
      .pause(pause), .abort(abort), .bal_out(bal_out), .sec(sec), .phase(phase),
      .st_light(st_light), .busy(busy), .paused(paused), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // cycle count used to schedule expectations
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [11:0] val(input sig_e s);
      case (s)
         S_BAL:   return bal_out;
         S_SEC:   return {4'h0, sec};
         S_PH:    return {10'h0, phase};
         S_LT:    return {9'h0, st_light};
         S_BUSY:  return {11'h0, busy};
         S_PSD:   return {11'h0, paused};
         S_DONE:  return {11'h0, done};
         default: return {11'h0, err};
      endcase
   endfunction

   // pop and compare every expectation due this cycle
   always @(negedge clk) begin
      if (done) done_cnt++;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].at == cyc) begin
            chk(q[i].tag, val(q[i].s), q[i].v);
            q.delete(i);
         end
   end

   task automatic ex(input int at, input sig_e s, input logic [11:0] v, input string tag);
      q.push_back('{at, s, v, tag});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic go(input logic [1:0] m, input logic [11:0] b, input logic [7:0] w, output int cs);
      mode = m;
      bal_in = b;
      wt = w;
      start = 1'b1;
      cs = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic pulse(input logic a, input logic p);
      abort = a;
      pause = p;
      step(1);
      abort = 1'b0;
      pause = 1'b0;
   endtask

   initial begin
      step(1);
      ex(cyc, S_BAL, 12'h000, "rst_bal");
      ex(cyc, S_SEC, 12'h000, "rst_sec");
      ex(cyc, S_PH, 12'h000, "rst_phase");
      ex(cyc, S_LT, 12'h000, "rst_light");
      ex(cyc, S_BUSY, 12'h000, "rst_busy");
      ex(cyc, S_DONE, 12'h000, "rst_done");
      ex(cyc, S_ERR, 12'h000, "rst_err");
      step(1);
      rst = 1'b1;
      step(1);
      // full mode 0 programme
      go(2'd0, 12'h050, 8'h05, c);
      ex(c + 1, S_BAL, 12'h045, "t1_bal");
      ex(c + 1, S_PH, 12'h001, "t1_ph_wash");
      ex(c + 1, S_SEC, 12'h020, "t1_sec_wash");
      ex(c + 1, S_LT, 12'h001, "t1_light_wash");
      ex(c + 80, S_SEC, 12'h001, "t1_sec_last");
      ex(c + 80, S_PH, 12'h001, "t1_ph_last_wash");
      ex(c + 81, S_PH, 12'h002, "t1_ph_rinse");
      ex(c + 81, S_SEC, 12'h010, "t1_sec_rinse");
      ex(c + 121, S_PH, 12'h003, "t1_ph_spin");
      ex(c + 121, S_LT, 12'h004, "t1_light_spin");
      ex(c + 160, S_DONE, 12'h000, "t1_done_early");
      ex(c + 161, S_DONE, 12'h001, "t1_done");
      ex(c + 161, S_SEC, 12'h000, "t1_done_sec");
      ex(c + 161, S_PH, 12'h000, "t1_done_ph");
      ex(c + 161, S_BUSY, 12'h000, "t1_done_busy");
      ex(c + 162, S_DONE, 12'h000, "t1_done_pulse");
      wait_to(c + 172);
      go(2'd3, 12'h050, 8'h00, c2);
      ex(c + 173, S_PH, 12'h000, "t1_start_ignored_ph");
      ex(c + 173, S_BAL, 12'h045, "t1_start_ignored_bal");
      step(1);
      chk("t1_done_count", 12'(done_cnt), 12'h001);
      // insufficient balance with heavy surcharge
      go(2'd2, 12'h013, 8'h12, c);
      ex(c + 1, S_ERR, 12'h001, "t2_err");
      ex(c + 1, S_BAL, 12'h013, "t2_bal");
      ex(c + 1, S_PH, 12'h000, "t2_ph");
      ex(c + 1, S_BUSY, 12'h000, "t2_busy");
      ex(c + 12, S_ERR, 12'h001, "t2_err_hold");
      ex(c + 13, S_ERR, 12'h000, "t2_err_end");
      wait_to(c + 13);
      // borrow across digits, heavy wash, BCD decrement 10 -> 09
      go(2'd1, 12'h100, 8'h10, c);
      ex(c + 1, S_BAL, 12'h090, "t3_bal");
      ex(c + 1, S_SEC, 12'h025, "t3_sec");
      ex(c + 1, S_PH, 12'h001, "t3_ph");
      ex(c + 64, S_SEC, 12'h010, "t3_sec_10");
      ex(c + 65, S_SEC, 12'h009, "t3_sec_09");
      wait_to(c + 66);
      pulse(1'b1, 1'b0);
      ex(c + 67, S_PH, 12'h000, "t3_abort_ph");
      ex(c + 67, S_SEC, 12'h000, "t3_abort_sec");
      ex(c + 67, S_BAL, 12'h090, "t3_abort_bal");
      ex(c + 67, S_BUSY, 12'h000, "t3_abort_busy");
      wait_to(c + 67);
      // spin-only programme; abort/pause alongside start in IDLE are ignored
      abort = 1'b1;
      pause = 1'b1;
      go(2'd3, 12'h004, 8'h03, c);
      abort = 1'b0;
      pause = 1'b0;
      ex(c + 1, S_BAL, 12'h000, "t4_bal");
      ex(c + 1, S_PH, 12'h003, "t4_ph");
      ex(c + 1, S_SEC, 12'h020, "t4_sec");
      ex(c + 1, S_LT, 12'h004, "t4_light");
      ex(c + 1, S_BUSY, 12'h001, "t4_busy");
      wait_to(c + 2);
      pulse(1'b1, 1'b0);
      ex(c + 3, S_BUSY, 12'h000, "t4_abort_busy");
      ex(c + 3, S_LT, 12'h000, "t4_abort_light");
      wait_to(c + 3);
      // pause freezes sec and the tick count
      go(2'd0, 12'h099, 8'h01, c);
      ex(c + 1, S_BAL, 12'h094, "t5_bal");
      wait_to(c + 14);
      pulse(1'b0, 1'b1);
      ex(c + 15, S_PSD, 12'h001, "t5_paused");
      ex(c + 15, S_SEC, 12'h017, "t5_sec_enter");
      ex(c + 40, S_SEC, 12'h017, "t5_sec_mid");
      ex(c + 40, S_BUSY, 12'h001, "t5_busy_mid");
      ex(c + 64, S_SEC, 12'h017, "t5_sec_late");
      ex(c + 64, S_PSD, 12'h001, "t5_paused_late");
      wait_to(c + 64);
      pulse(1'b0, 1'b1);
      ex(c + 65, S_PSD, 12'h000, "t5_resumed");
      ex(c + 67, S_SEC, 12'h017, "t5_sec_before_tick");
      ex(c + 68, S_SEC, 12'h016, "t5_sec_after_tick");
      ex(c + 68, S_PH, 12'h001, "t5_ph");
      wait_to(c + 70);
      pulse(1'b1, 1'b1);
      ex(c + 71, S_BUSY, 12'h000, "t5_abort_busy");
      ex(c + 71, S_PSD, 12'h000, "t5_abort_paused");
      ex(c + 71, S_BAL, 12'h094, "t5_abort_bal");
      ex(c + 71, S_PH, 12'h000, "t5_abort_ph");
      wait_to(c + 71);
      // invalid weight digit
      go(2'd0, 12'h050, 8'h0A, c);
      ex(c + 1, S_ERR, 12'h001, "t6_err");
      ex(c + 1, S_BAL, 12'h050, "t6_bal");
      wait_to(c + 2);
      pulse(1'b1, 1'b0);
      ex(c + 3, S_ERR, 12'h000, "t6_abort_err");
      wait_to(c + 3);
      // asynchronous reset in the middle of spin
      go(2'd3, 12'h010, 8'h00, c);
      ex(c + 1, S_BAL, 12'h006, "t7_bal");
      ex(c + 1, S_PH, 12'h003, "t7_ph");
      wait_to(c + 5);
      rst = 1'b0;
      ex(c + 5, S_BAL, 12'h000, "t7_rst_bal");
      ex(c + 5, S_SEC, 12'h000, "t7_rst_sec");
      ex(c + 5, S_PH, 12'h000, "t7_rst_ph");
      ex(c + 5, S_LT, 12'h000, "t7_rst_light");
      ex(c + 5, S_BUSY, 12'h000, "t7_rst_busy");
      step(1);
      rst = 1'b1;
      step(3);
      foreach (q[i]) begin
         miscompares++;
         $display("FAIL %s: never checked, expected %h at cycle %0d", q[i].tag, q[i].v, q[i].at);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
